// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package program_loader_pkg;

  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 16;
  localparam int MAX_LEN = DEPTH;

  typedef enum logic [2:0] {
    HDR,
    HI,
    LO,
    CHK,
    RUN,
    ERR
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface program_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/program_loader.sv
// Boot loader: length header, N two-byte instruction words, XOR checksum.
// Writes words into instruction memory and releases the CPU on a good load.
module program_loader
  import program_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  program_loader_if.slave      in_bus,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0]   imem_wdata,
  output logic                 cpu_run,
  output logic                 load_error,
  output logic [ADDR_W:0]      words_loaded
);

  localparam logic [ADDR_W:0] WORD_ONE = 1;

  loader_state_t   state;
  loader_state_t   state_next;
  logic [ADDR_W:0] len;
  logic [7:0]      acc;
  logic [7:0]      hi_byte;
  logic            accept;
  logic            last_word;

  assign accept    = in_bus.in_valid && in_bus.in_ready;
  assign last_word = (words_loaded + WORD_ONE) == len;

  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: if (accept) begin
        if (in_bus.in_data == 8'd0 || in_bus.in_data > 8'(MAX_LEN)) state_next = ERR;
        else                                                        state_next = HI;
      end
      HI:  if (accept) state_next = LO;
      LO:  if (accept) state_next = last_word ? CHK : HI;
      CHK: if (accept) state_next = (in_bus.in_data == acc) ? RUN : ERR;
      RUN: state_next = RUN;
      ERR: state_next = ERR;
      default: state_next = HDR;
    endcase
  end

  // Status outputs are registered from the next state, so ready drops on the
  // same edge that enters RUN/ERR and no extra byte slips through.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_bus.in_ready <= 1'b0;
      cpu_run         <= 1'b0;
      load_error      <= 1'b0;
      imem_we         <= 1'b0;
      imem_addr       <= '0;
      imem_wdata      <= '0;
      words_loaded    <= '0;
      len             <= '0;
      acc             <= '0;
      hi_byte         <= '0;
    end else begin
      in_bus.in_ready <= state_next inside {HDR, HI, LO, CHK};
      cpu_run         <= state_next == RUN;
      load_error      <= state_next == ERR;
      imem_we         <= 1'b0;
      if (accept) begin
        case (state)
          HDR: begin
            len <= in_bus.in_data[ADDR_W:0];
            acc <= '0;
          end
          HI: begin
            hi_byte <= in_bus.in_data;
            acc     <= acc ^ in_bus.in_data;
          end
          LO: begin
            acc          <= acc ^ in_bus.in_data;
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= {hi_byte, in_bus.in_data};
            words_loaded <= words_loaded + WORD_ONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a stream-level
// model: header/words/checksum decoded directly from the byte list.
module tb_program_loader;
  import program_loader_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 imem_we;
  logic [ADDR_W-1:0]    imem_addr;
  logic [INSTR_W-1:0]   imem_wdata;
  logic                 cpu_run;
  logic                 load_error;
  logic [ADDR_W:0]      words_loaded;

  program_loader_if bus();

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_bus       (bus),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          num_checks = 0;
  int          num_fail   = 0;
  logic [7:0]  stim_q[$];
  int unsigned exp_addr[$];
  int unsigned exp_data[$];
  int unsigned got_addr[$];
  int unsigned got_data[$];
  int          exp_words;
  logic        exp_run;
  logic        exp_err;
  int          back2back = 0;
  logic        prev_we   = 1'b0;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      if (prev_we) back2back++;
    end
    prev_we = imem_we;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_imem_we", imem_we, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    checkOutput("rst_imem_wdata", imem_wdata, 0);
    checkOutput("rst_cpu_run", cpu_run, 0);
    checkOutput("rst_load_error", load_error, 0);
    checkOutput("rst_words_loaded", words_loaded, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkResetState();
    @(negedge clk);
    checkOutput("ready_after_rst", bus.in_ready, 1);
    got_addr.delete();
    got_data.delete();
    back2back = 0;
  endtask

  // Reference: decode the byte list as header, N big-endian words, checksum.
  task automatic buildExpected();
    int         n;
    logic [7:0] cs;
    exp_addr.delete();
    exp_data.delete();
    n         = int'(stim_q[0]);
    exp_run   = 1'b0;
    exp_err   = 1'b1;
    exp_words = 0;
    if (n >= 1 && n <= DEPTH) begin
      cs = 8'h00;
      for (int w = 0; w < n; w++) begin
        exp_addr.push_back(w);
        exp_data.push_back({stim_q[1+2*w], stim_q[2+2*w]});
        cs = cs ^ stim_q[1+2*w] ^ stim_q[2+2*w];
      end
      exp_words = n;
      exp_run   = (stim_q[2*n+1] == cs);
      exp_err   = !exp_run;
    end
  endtask

  task automatic makeProgram(input int n, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    stim_q.delete();
    stim_q.push_back(8'(n));
    cs = 8'h00;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      stim_q.push_back(b);
      cs = cs ^ b;
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    stim_q.push_back(cs);
  endtask

  task automatic applyStimulus(input int gap_pct, input int nbytes);
    int wait_n;
    for (int i = 0; i < nbytes; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
      wait_n = 0;
      while (!bus.in_ready && wait_n < 50) begin
        @(negedge clk);
        wait_n++;
      end
      if (!bus.in_ready) begin
        checkOutput("handshake_ready", bus.in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic checkLoad(input string tag);
    checkOutput({tag, "_n_writes"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    checkOutput({tag, "_words_loaded"}, words_loaded, exp_words);
    checkOutput({tag, "_cpu_run"}, cpu_run, exp_run);
    checkOutput({tag, "_load_error"}, load_error, exp_err);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
    checkOutput({tag, "_back2back_we"}, back2back, 0);
  endtask

  task automatic runLoad(input string tag, input int gap_pct);
    doReset();
    buildExpected();
    applyStimulus(gap_pct, stim_q.size());
    repeat (3) @(negedge clk);
    checkLoad(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Nominal load, then back-pressure in RUN.
    stim_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    runLoad("nominal", 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    checkOutput("bp_n_writes", got_addr.size(), 2);
    checkOutput("bp_words_loaded", words_loaded, 2);
    checkOutput("bp_cpu_run", cpu_run, 1);

    stim_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    runLoad("bad_cs", 0);

    stim_q = '{8'h00};
    runLoad("hdr_zero", 0);
    stim_q = '{8'h41};
    runLoad("hdr_65", 0);

    makeProgram(DEPTH, 1'b0);
    runLoad("full_depth", 40);

    // Reset mid-load with a byte offered during reset, then a clean reload.
    doReset();
    makeProgram(5, 1'b0);
    applyStimulus(0, 7);
    @(negedge clk);
    checkOutput("partial_n_writes", got_addr.size(), 3);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checkResetState();
    @(negedge clk);
    got_addr.delete();
    got_data.delete();
    back2back = 0;
    stim_q = '{8'h01, 8'h00, 8'h07, 8'h07};
    buildExpected();
    applyStimulus(0, stim_q.size());
    repeat (3) @(negedge clk);
    checkLoad("reload");

    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        stim_q.delete();
        stim_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255)));
      end else begin
        n = $urandom_range(1, DEPTH);
        makeProgram(n, $urandom_range(0, 9) < 3);
      end
      runLoad($sformatf("rand%0d", t), $urandom_range(0, 60));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
